// File: rtl/uart_tx_fifo_ext_if.sv
// rtl/uart_tx_fifo_ext_if.sv - write/read handshake and status bundle for the TX byte FIFO
interface uart_tx_fifo_ext_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic                    flush;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/uart_tx_fifo_ext.sv
// rtl/uart_tx_fifo_ext.sv - TX byte FIFO with occupancy, watermarks, sticky errors and FWFT option
module uart_tx_fifo_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input logic               clk,
  input logic               rst,
  uart_tx_fifo_ext_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, wr_accept, rd_accept;

  // Acceptance is judged on pre-edge flags; reset and flush swallow both requests.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign wr_accept = bus.wr_en && !full  && !bus.flush && !rst;
  assign rd_accept = bus.rd_en && !empty && !bus.flush && !rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + ONE;
      if (wr_accept && !rd_accept)      count_d = count_q + ONE;
      else if (rd_accept && !wr_accept) count_d = count_q - ONE;
      if (bus.wr_en && full)  overflow_d  = 1'b1;
      if (bus.rd_en && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rd_data  = mem_q[rd_ptr_q[AW-1:0]];
      assign bus.rd_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (bus.flush) begin
          rd_data_d = '0;
        end else if (rd_accept) begin
          rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
          rd_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_uart_tx_fifo_ext.sv
// tb/tb_uart_tx_fifo_ext.sv - directed bench for the TX FIFO in registered and FWFT read modes
module tb_uart_tx_fifo_ext;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_d;

  uart_tx_fifo_ext_if #(.DATA_WIDTH(8), .DEPTH(16)) bs ();
  uart_tx_fifo_ext_if #(.DATA_WIDTH(8), .DEPTH(16)) bf ();

  uart_tx_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (bs)
  );

  uart_tx_fifo_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) u_fw (
    .clk (clk),
    .rst (rst),
    .bus (bf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (bs.count !== 5'd0) $display("FAIL reset_count got %0d exp 0", bs.count); else n_pass++;
    n_total++; if (bs.empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", bs.empty); else n_pass++;
    n_total++; if (bs.almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", bs.almost_empty); else n_pass++;
    n_total++; if (bs.full !== 1'b0 || bs.almost_full !== 1'b0) $display("FAIL reset_full got %b%b exp 00", bs.full, bs.almost_full); else n_pass++;
    n_total++; if (bs.overflow !== 1'b0 || bs.underflow !== 1'b0) $display("FAIL reset_sticky got %b%b exp 00", bs.overflow, bs.underflow); else n_pass++;
    n_total++; if (bs.rd_data !== 8'h00 || bs.rd_valid !== 1'b0) $display("FAIL reset_rd got %h/%b exp 00/0", bs.rd_data, bs.rd_valid); else n_pass++;
    n_total++; if (bf.empty !== 1'b1 || bf.rd_valid !== 1'b0) $display("FAIL reset_fwft got %b/%b exp 1/0", bf.empty, bf.rd_valid); else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      bs.wr_en = 1'b1;
      bs.wr_data = 8'(i);
      tick();
      n_total++; if (bs.count !== 5'(i + 1)) $display("FAIL fill_count[%0d] got %0d exp %0d", i, bs.count, i + 1); else n_pass++;
      n_total++; if (bs.almost_full !== (i + 1 >= 14)) $display("FAIL fill_af[%0d] got %b", i, bs.almost_full); else n_pass++;
      n_total++; if (bs.full !== (i + 1 == 16)) $display("FAIL fill_full[%0d] got %b", i, bs.full); else n_pass++;
      n_total++; if (bs.empty !== 1'b0) $display("FAIL fill_empty[%0d] got %b exp 0", i, bs.empty); else n_pass++;
    end
    bs.wr_data = 8'hAA;
    tick();
    bs.wr_en = 1'b0;
    n_total++; if (bs.count !== 5'd16) $display("FAIL overflow_count got %0d exp 16", bs.count); else n_pass++;
    n_total++; if (bs.overflow !== 1'b1) $display("FAIL overflow_flag got %b exp 1", bs.overflow); else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      bs.rd_en = 1'b1;
      tick();
      bs.rd_en = 1'b0;
      n_total++; if (bs.rd_valid !== 1'b1 || bs.rd_data !== 8'(i)) $display("FAIL drain[%0d] got %h/%b exp %h/1", i, bs.rd_data, bs.rd_valid, 8'(i)); else n_pass++;
      tick();
      n_total++; if (bs.rd_valid !== 1'b0) $display("FAIL drain_pulse[%0d] got %b exp 0", i, bs.rd_valid); else n_pass++;
    end
    n_total++; if (bs.empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", bs.empty); else n_pass++;
    bs.rd_en = 1'b1;
    tick();
    bs.rd_en = 1'b0;
    n_total++; if (bs.underflow !== 1'b1) $display("FAIL underflow_flag got %b exp 1", bs.underflow); else n_pass++;
    n_total++; if (bs.rd_valid !== 1'b0 || bs.rd_data !== 8'h0F) $display("FAIL underflow_rd got %h/%b exp 0f/0", bs.rd_data, bs.rd_valid); else n_pass++;
    n_total++; if (bs.overflow !== 1'b1) $display("FAIL overflow_sticky got %b exp 1", bs.overflow); else n_pass++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      bs.wr_en = 1'b1;
      bs.wr_data = 8'(8'h30 + i);
      tick();
    end
    n_total++; if (bs.count !== 5'd7) $display("FAIL flush_pre_count got %0d exp 7", bs.count); else n_pass++;
    bs.flush = 1'b1;
    bs.wr_data = 8'h77;
    tick();
    bs.flush = 1'b0;
    bs.wr_en = 1'b0;
    n_total++; if (bs.count !== 5'd0 || bs.empty !== 1'b1) $display("FAIL flush_count got %0d/%b exp 0/1", bs.count, bs.empty); else n_pass++;
    n_total++; if (bs.overflow !== 1'b0 || bs.underflow !== 1'b0) $display("FAIL flush_sticky got %b%b exp 00", bs.overflow, bs.underflow); else n_pass++;
    bs.wr_en = 1'b1;
    bs.wr_data = 8'h11;
    tick();
    bs.wr_en = 1'b0;
    bs.rd_en = 1'b1;
    tick();
    bs.rd_en = 1'b0;
    n_total++; if (bs.rd_data !== 8'h11 || bs.count !== 5'd0) $display("FAIL flush_reuse got %h/%0d exp 11/0", bs.rd_data, bs.count); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      int n;
      logic [7:0] base;
      n = (pass == 0) ? 10 : 12;
      base = (pass == 0) ? 8'h40 : 8'h80;
      for (int i = 0; i < n; i++) begin
        bs.wr_en = 1'b1;
        bs.wr_data = base + 8'(i);
        tick();
      end
      bs.wr_en = 1'b0;
      for (int i = 0; i < n; i++) begin
        bs.rd_en = 1'b1;
        tick();
        n_total++; if (bs.rd_data !== base + 8'(i)) $display("FAIL wrap[%0d][%0d] got %h exp %h", pass, i, bs.rd_data, base + 8'(i)); else n_pass++;
      end
      bs.rd_en = 1'b0;
    end
    n_total++; if (bs.count !== 5'd0 || bs.empty !== 1'b1) $display("FAIL wrap_count got %0d exp 0", bs.count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    model_q.delete();
    for (int i = 0; i < 5; i++) begin
      bs.wr_en = 1'b1;
      bs.wr_data = 8'(8'hC0 + i);
      model_q.push_back(bs.wr_data);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      bs.rd_en = 1'b1;
      bs.wr_data = 8'(8'hD0 + i);
      model_q.push_back(bs.wr_data);
      exp_d = model_q.pop_front();
      tick();
      n_total++; if (bs.rd_valid !== 1'b1 || bs.rd_data !== exp_d) $display("FAIL b2b_data[%0d] got %h/%b exp %h/1", i, bs.rd_data, bs.rd_valid, exp_d); else n_pass++;
      n_total++; if (bs.count !== 5'd5) $display("FAIL b2b_count[%0d] got %0d exp 5", i, bs.count); else n_pass++;
    end
    bs.wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_d = model_q.pop_front();
      tick();
      n_total++; if (bs.rd_data !== exp_d) $display("FAIL b2b_tail[%0d] got %h exp %h", i, bs.rd_data, exp_d); else n_pass++;
    end
    bs.rd_en = 1'b0;
    n_total++; if (bs.empty !== 1'b1) $display("FAIL b2b_empty got %b exp 1", bs.empty); else n_pass++;
  endtask

  task automatic test_simultaneous_bounds();
    bs.flush = 1'b1;
    tick();
    bs.flush = 1'b0;
    bs.wr_en = 1'b1;
    bs.rd_en = 1'b1;
    bs.wr_data = 8'hE0;
    tick();
    bs.rd_en = 1'b0;
    n_total++; if (bs.count !== 5'd1 || bs.underflow !== 1'b1 || bs.rd_valid !== 1'b0) $display("FAIL sim_empty got %0d/%b/%b exp 1/1/0", bs.count, bs.underflow, bs.rd_valid); else n_pass++;
    for (int i = 1; i < 16; i++) begin
      bs.wr_data = 8'(8'hE0 + i);
      tick();
    end
    n_total++; if (bs.full !== 1'b1) $display("FAIL sim_fill got %b exp 1", bs.full); else n_pass++;
    bs.rd_en = 1'b1;
    bs.wr_data = 8'hFF;
    tick();
    bs.wr_en = 1'b0;
    bs.rd_en = 1'b0;
    n_total++; if (bs.count !== 5'd15 || bs.overflow !== 1'b1) $display("FAIL sim_full got %0d/%b exp 15/1", bs.count, bs.overflow); else n_pass++;
    n_total++; if (bs.rd_valid !== 1'b1 || bs.rd_data !== 8'hE0) $display("FAIL sim_full_rd got %h/%b exp e0/1", bs.rd_data, bs.rd_valid); else n_pass++;
    bs.flush = 1'b1;
    tick();
    bs.flush = 1'b0;
    n_total++; if (bs.rd_data !== 8'h00 || bs.count !== 5'd0) $display("FAIL sim_flush got %h/%0d exp 00/0", bs.rd_data, bs.count); else n_pass++;
  endtask

  task automatic test_fwft();
    bf.wr_en = 1'b1;
    bf.wr_data = 8'h5A;
    tick();
    bf.wr_en = 1'b0;
    n_total++; if (bf.rd_valid !== 1'b1 || bf.rd_data !== 8'h5A) $display("FAIL fwft_show got %h/%b exp 5a/1", bf.rd_data, bf.rd_valid); else n_pass++;
    tick();
    n_total++; if (bf.rd_valid !== 1'b1 || bf.count !== 5'd1) $display("FAIL fwft_hold got %b/%0d exp 1/1", bf.rd_valid, bf.count); else n_pass++;
    bf.rd_en = 1'b1;
    tick();
    bf.rd_en = 1'b0;
    n_total++; if (bf.empty !== 1'b1 || bf.rd_valid !== 1'b0) $display("FAIL fwft_pop got %b/%b exp 1/0", bf.empty, bf.rd_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    bf.rd_en = 1'b1;
    bs.wr_en = 1'b1;
    bs.wr_data = 8'h21;
    tick();
    bf.rd_en = 1'b0;
    bf.wr_en = 1'b1;
    bf.wr_data = 8'h61;
    bs.wr_data = 8'h22;
    tick();
    bf.wr_data = 8'h62;
    bs.wr_en = 1'b0;
    bs.rd_en = 1'b1;
    tick();
    n_total++; if (bs.rd_data !== 8'h21 || bs.rd_valid !== 1'b1) $display("FAIL burst_std got %h/%b exp 21/1", bs.rd_data, bs.rd_valid); else n_pass++;
    n_total++; if (bf.count !== 5'd2 || bf.underflow !== 1'b1 || bf.rd_data !== 8'h61) $display("FAIL burst_fwft got %0d/%b/%h exp 2/1/61", bf.count, bf.underflow, bf.rd_data); else n_pass++;
    rst = 1'b1;
    bf.wr_data = 8'h63;
    tick();
    rst = 1'b0;
    bf.wr_en = 1'b0;
    bs.rd_en = 1'b0;
    n_total++; if (bf.count !== 5'd0 || bf.empty !== 1'b1 || bf.rd_valid !== 1'b0) $display("FAIL rst_fwft got %0d/%b/%b exp 0/1/0", bf.count, bf.empty, bf.rd_valid); else n_pass++;
    n_total++; if (bf.underflow !== 1'b0 || bf.overflow !== 1'b0 || bf.almost_empty !== 1'b1 || bf.full !== 1'b0) $display("FAIL rst_fwft_flags got %b%b%b%b exp 0010", bf.underflow, bf.overflow, bf.almost_empty, bf.full); else n_pass++;
    n_total++; if (bs.count !== 5'd0 || bs.rd_valid !== 1'b0 || bs.rd_data !== 8'h00) $display("FAIL rst_std got %0d/%b/%h exp 0/0/00", bs.count, bs.rd_valid, bs.rd_data); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bs.flush = 1'b0; bs.wr_en = 1'b0; bs.wr_data = 8'h00; bs.rd_en = 1'b0;
    bf.flush = 1'b0; bf.wr_en = 1'b0; bf.wr_data = 8'h00; bf.rd_en = 1'b0;
    tick();
    test_reset();
    test_fill();
    test_drain();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_simultaneous_bounds();
    test_fwft();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
